// File: rtl/br_bank.sv
// Small register bank with single-cycle load/clear/increment and bit-serial shifts.
// All state advances on the falling clock edge; read ports are registered with write-through.
module br_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int SW    = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    amt,
    input  logic [AW-1:0]    xsel,
    input  logic [AW-1:0]    ysel,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_CLEAR = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_SHR   = 3'd3;
    localparam logic [2:0] OP_SAR   = 3'd4;
    localparam logic [2:0] OP_INC   = 3'd5;

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_sh_sel;
    logic [2:0]       r_sh_op;
    logic [SW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_alu_x;
    logic [WIDTH-1:0] r_alu_y;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_mem_nxt [DEPTH];
    logic [AW-1:0]    w_sh_sel_nxt;
    logic [2:0]       w_sh_op_nxt;
    logic [SW-1:0]    w_cnt_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [DEPTH-1:0] w_wsel_hit;
    logic             w_accept;
    logic [WIDTH-1:0] w_rd_x;
    logic [WIDTH-1:0] w_rd_y;

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v, input logic [2:0] sop);
        logic [WIDTH-1:0] res;
        case (sop)
            OP_SHL:  res = {v[WIDTH-2:0], 1'b0};
            OP_SHR:  res = {1'b0, v[WIDTH-1:1]};
            OP_SAR:  res = {v[WIDTH-1], v[WIDTH-1:1]};
            default: res = v;
        endcase
        return res;
    endfunction

    // Command decode: target-entry match and acceptance qualification.
    always_comb begin
        w_wsel_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wsel_hit[i] = (wsel == AW'(i));
        end
        w_accept = ld && !r_busy && (op <= OP_INC) && (|w_wsel_hit);
    end

    // Next-state, next-entry and completion logic for the IDLE/SHIFT controller.
    always_comb begin
        w_state_nxt  = r_state;
        w_mem_nxt    = r_mem;
        w_sh_sel_nxt = r_sh_sel;
        w_sh_op_nxt  = r_sh_op;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (op)
                        OP_LOAD: begin
                            for (int i = 0; i < DEPTH; i++) begin
                                w_mem_nxt[i] = w_wsel_hit[i] ? din : r_mem[i];
                            end
                            w_done_nxt = 1'b1;
                        end
                        OP_CLEAR: begin
                            for (int i = 0; i < DEPTH; i++) begin
                                w_mem_nxt[i] = w_wsel_hit[i] ? {WIDTH{1'b0}} : r_mem[i];
                            end
                            w_done_nxt = 1'b1;
                        end
                        OP_INC: begin
                            for (int i = 0; i < DEPTH; i++) begin
                                w_mem_nxt[i] = w_wsel_hit[i] ? (r_mem[i] + WIDTH'(1'b1)) : r_mem[i];
                            end
                            w_done_nxt = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_SAR: begin
                            if (amt == {SW{1'b0}}) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt  = ST_SHIFT;
                                w_busy_nxt   = 1'b1;
                                w_cnt_nxt    = amt;
                                w_sh_sel_nxt = wsel;
                                w_sh_op_nxt  = op;
                            end
                        end
                        default: begin
                            w_done_nxt = 1'b0;
                        end
                    endcase
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                for (int i = 0; i < DEPTH; i++) begin
                    w_mem_nxt[i] = (r_sh_sel == AW'(i)) ? shift_one(r_mem[i], r_sh_op) : r_mem[i];
                end
                w_cnt_nxt = r_cnt - SW'(1'b1);
                // The step that empties the counter is the last one and completes the command.
                if (r_cnt == SW'(1'b1)) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Read-port muxes see the post-update entries; out-of-range selects yield zero.
    always_comb begin
        w_rd_x = {WIDTH{1'b0}};
        w_rd_y = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_rd_x = (xsel == AW'(i)) ? w_mem_nxt[i] : w_rd_x;
            w_rd_y = (ysel == AW'(i)) ? w_mem_nxt[i] : w_rd_y;
        end
    end

    // State, entry and output registers, falling-edge clocked with async active-low reset.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_sh_sel <= {AW{1'b0}};
            r_sh_op  <= 3'd0;
            r_cnt    <= {SW{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_alu_x  <= {WIDTH{1'b0}};
            r_alu_y  <= {WIDTH{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_mem    <= w_mem_nxt;
            r_sh_sel <= w_sh_sel_nxt;
            r_sh_op  <= w_sh_op_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_alu_x  <= w_rd_x;
            r_alu_y  <= w_rd_y;
        end
    end

    assign alu_x = r_alu_x;
    assign alu_y = r_alu_y;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
